// File: rtl/spi_sample_reader.sv
// spi_sample_reader: mode-0 SPI host that reads one WORD_WIDTH-bit sample per start request.
module spi_sample_reader #(
  parameter int WORD_WIDTH = 10,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  sclk_o,
  output logic                  cs_o,
  input  logic                  sdi_i
);
  localparam int MX0 = CS_SETUP > CLK_DIV ? CS_SETUP : CLK_DIV;
  localparam int MX  = MX0 > CS_HOLD ? MX0 : CS_HOLD;
  localparam int CW  = $clog2(MX + 1);
  localparam int BW  = $clog2(WORD_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt, w_lim;
  logic [BW-1:0]         r_bits, w_bits;
  logic [WORD_WIDTH-1:0] r_sr, w_sr, r_data, w_data;
  logic                  r_sclk, w_sclk, r_cs, w_cs, r_busy, w_busy, r_valid, w_valid, w_tc;
  // one shared counter times the setup, each sclk half-period and the hold
  assign w_lim = r_state == SETUP ? CW'(CS_SETUP - 1) : r_state == SHIFT ? CW'(CLK_DIV - 1) : CW'(CS_HOLD - 1);
  assign w_tc  = r_cnt == w_lim;
  always_comb begin
    w_state = r_state;
    w_cnt   = w_tc ? '0 : r_cnt + 1'b1;
    w_sclk  = r_sclk;
    w_cs    = r_cs;
    w_busy  = r_busy;
    w_valid = 1'b0;
    w_data  = r_data;
    w_sr    = r_sr;
    w_bits  = r_bits;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (start_i) begin
          w_state = SETUP;
          w_cs    = 1'b0;
          w_busy  = 1'b1;
          w_bits  = '0;
        end
      end
      SETUP: if (w_tc) w_state = SHIFT;
      SHIFT: if (w_tc) begin
        w_sclk = ~r_sclk;
        if (!r_sclk) begin
          w_sr   = {r_sr[WORD_WIDTH-2:0], sdi_i};
          w_bits = r_bits + 1'b1;
        end else if (r_bits == BW'(WORD_WIDTH)) w_state = HOLD;
      end
      HOLD: if (w_tc) begin
        w_state = IDLE;
        w_cs    = 1'b1;
        w_busy  = 1'b0;
        w_valid = 1'b1;
        w_data  = r_sr;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_sr    <= '0;
      r_data  <= '0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bits  <= w_bits;
      r_sr    <= w_sr;
      r_data  <= w_data;
      r_sclk  <= w_sclk;
      r_cs    <= w_cs;
      r_busy  <= w_busy;
      r_valid <= w_valid;
    end
  end
  assign busy_o  = r_busy;
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign sclk_o  = r_sclk;
  assign cs_o    = r_cs;
endmodule

// File: tb/tb_spi_sample_reader.sv
// tb_spi_sample_reader: directed tests with SPI peripheral models for a default and a fast instance.
module tb_spi_sample_reader;
  logic clk = 1'b0, rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, valid0, sclk0, cs0, sdi0, busy1, valid1, sclk1, cs1, sdi1;
  logic [9:0] data0, p0_word = '0;
  logic [15:0] data1, p1_word = '0;
  int p0_idx = 0, p1_idx = 0;
  int chk_cnt = 0, pass_cnt = 0;
  always #5 clk = ~clk;
  spi_sample_reader u0 (.clk(clk), .rst(rst), .start_i(start0), .busy_o(busy0), .data_o(data0),
    .valid_o(valid0), .sclk_o(sclk0), .cs_o(cs0), .sdi_i(sdi0));
  spi_sample_reader #(.WORD_WIDTH(16), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u1 (.clk(clk), .rst(rst),
    .start_i(start1), .busy_o(busy1), .data_o(data1), .valid_o(valid1), .sclk_o(sclk1), .cs_o(cs1), .sdi_i(sdi1));
  // peripherals: MSB presented while cs is high/at cs fall, next bit after each sclk fall
  always @(negedge sclk0 or posedge cs0) p0_idx <= cs0 ? 0 : p0_idx + 1;
  always @(negedge sclk1 or posedge cs1) p1_idx <= cs1 ? 0 : p1_idx + 1;
  assign sdi0 = p0_idx < 10 ? p0_word[9 - p0_idx] : 1'b0;
  assign sdi1 = p1_idx < 16 ? p1_word[15 - p1_idx] : 1'b0;

  task automatic xfer(input logic [9:0] w, input int p1, input int p2, output int vcnt, output int vt,
                      output int nr, output int fr, output int lr, output int gap_bad, output int csl,
                      output logic [9:0] d);
    logic prev;
    vcnt = 0; vt = -1; nr = 0; fr = -1; lr = -1; gap_bad = 0; d = 'x;
    p0_word = w;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    csl = cs0 ? 0 : 1;
    prev = sclk0;
    for (int c = 1; c < 100; c++) begin
      @(posedge clk); #1;
      start0 = (c == p1 - 1 || c == p2 - 1);
      if (!cs0) csl++;
      if (sclk0 && !prev) begin
        nr++;
        if (nr == 1) fr = c;
        else if (c - lr != 8) gap_bad++;
        lr = c;
      end
      prev = sclk0;
      if (valid0) begin vcnt++; vt = c; d = data0; end
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if ({cs0, sclk0, busy0, valid0} !== 4'b1000) $display("FAIL reset_ctl0 got %b want 1000", {cs0, sclk0, busy0, valid0}); else pass_cnt++;
    chk_cnt++; if (data0 !== 10'h000) $display("FAIL reset_data0 got %h want 000", data0); else pass_cnt++;
    chk_cnt++; if ({cs1, sclk1, busy1, valid1, data1} !== {4'b1000, 16'h0000}) $display("FAIL reset_u1 got %b/%h want 1000/0000", {cs1, sclk1, busy1, valid1}, data1); else pass_cnt++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single;
    int vcnt, vt, nr, fr, lr, gb, csl;
    logic [9:0] d;
    xfer(10'h2A5, 0, 0, vcnt, vt, nr, fr, lr, gb, csl, d);
    chk_cnt++; if (vcnt !== 1) $display("FAIL single_vcnt got %0d want 1", vcnt); else pass_cnt++;
    chk_cnt++; if (vt !== 84) $display("FAIL single_vtime got %0d want 84", vt); else pass_cnt++;
    chk_cnt++; if (d !== 10'h2A5) $display("FAIL single_data got %h want 2a5", d); else pass_cnt++;
    chk_cnt++; if (nr !== 10) $display("FAIL single_rises got %0d want 10", nr); else pass_cnt++;
    chk_cnt++; if (fr !== 6 || lr !== 78) $display("FAIL single_rise_pos got %0d..%0d want 6..78", fr, lr); else pass_cnt++;
    chk_cnt++; if (gb !== 0) $display("FAIL single_rise_gap got %0d bad want 0", gb); else pass_cnt++;
    chk_cnt++; if (csl !== 84) $display("FAIL single_cs_low got %0d want 84", csl); else pass_cnt++;
  endtask

  task automatic test_patterns;
    logic [9:0] pats [4] = '{10'h000, 10'h3FF, 10'h001, 10'h200};
    int vcnt, vt, nr, fr, lr, gb, csl;
    logic [9:0] d;
    for (int i = 0; i < 4; i++) begin
      xfer(pats[i], 0, 0, vcnt, vt, nr, fr, lr, gb, csl, d);
      chk_cnt++; if (vcnt !== 1 || d !== pats[i]) $display("FAIL pattern%0d got %h (valids %0d) want %h", i, d, vcnt, pats[i]); else pass_cnt++;
    end
  endtask

  task automatic test_ignore;
    int vcnt, vt, nr, fr, lr, gb, csl;
    logic [9:0] d;
    xfer(10'h155, 10, 50, vcnt, vt, nr, fr, lr, gb, csl, d);
    chk_cnt++; if (vcnt !== 1 || vt !== 84) $display("FAIL ignore_valid got %0d at %0d want 1 at 84", vcnt, vt); else pass_cnt++;
    chk_cnt++; if (d !== 10'h155) $display("FAIL ignore_data got %h want 155", d); else pass_cnt++;
    chk_cnt++; if (nr !== 10) $display("FAIL ignore_rises got %0d want 10", nr); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] words [3] = '{10'h3C1, 10'h0F0, 10'h2A5};
    int vt [3] = '{-1, -1, -1};
    int n = 0, run = 0, runs_bad = 0, runs = 0;
    logic prev_cs;
    p0_word = words[0];
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1;
    prev_cs = cs0;
    for (int c = 1; c < 262; c++) begin
      @(posedge clk); #1;
      if (cs0) run++;
      else if (prev_cs) begin runs++; if (run != 1) runs_bad++; run = 0; end
      prev_cs = cs0;
      if (valid0 && n < 3) begin
        vt[n] = c;
        chk_cnt++; if (data0 !== words[n]) $display("FAIL b2b_data%0d got %h want %h", n, data0, words[n]); else pass_cnt++;
        n++;
        if (n < 3) p0_word = words[n];
      end
    end
    start0 = 1'b0;
    chk_cnt++; if (vt[0] !== 84 || vt[1] !== 169 || vt[2] !== 254) $display("FAIL b2b_times got %0d,%0d,%0d want 84,169,254", vt[0], vt[1], vt[2]); else pass_cnt++;
    chk_cnt++; if (runs !== 3 || runs_bad !== 0) $display("FAIL b2b_cs_gap got %0d gaps %0d bad want 3 gaps 0 bad", runs, runs_bad); else pass_cnt++;
    for (int c = 0; c < 200 && busy0; c++) @(posedge clk);
    #1;
    chk_cnt++; if (busy0 !== 1'b0) $display("FAIL b2b_drain busy %b want 0", busy0); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int vcnt = 0, nr, fr, lr, gb, csl, vt;
    logic [9:0] d;
    p0_word = 10'h3AA;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int c = 1; c < 130; c++) begin
      @(posedge clk); #1;
      rst = (c == 39);
      if (c == 40) begin
        chk_cnt++; if ({cs0, sclk0, busy0} !== 3'b100) $display("FAIL rstmid_ctl got %b want 100", {cs0, sclk0, busy0}); else pass_cnt++;
        chk_cnt++; if (data0 !== 10'h000) $display("FAIL rstmid_data got %h want 000", data0); else pass_cnt++;
      end
      if (valid0) vcnt++;
    end
    chk_cnt++; if (vcnt !== 0) $display("FAIL rstmid_novalid got %0d want 0", vcnt); else pass_cnt++;
    xfer(10'h0C3, 0, 0, vcnt, vt, nr, fr, lr, gb, csl, d);
    chk_cnt++; if (vcnt !== 1 || vt !== 84 || d !== 10'h0C3) $display("FAIL rstmid_after got %h (%0d at %0d) want 0c3 (1 at 84)", d, vcnt, vt); else pass_cnt++;
  endtask

  task automatic test_fast;
    int vcnt = 0, vt = -1, nr = 0, lr = -1, gb = 0;
    logic [15:0] d = 'x;
    logic prev;
    p1_word = 16'hA5C3;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    prev = sclk1;
    for (int c = 1; c < 60; c++) begin
      @(posedge clk); #1;
      if (sclk1 && !prev) begin
        nr++;
        if (c != 2 * nr) gb++;
        lr = c;
      end
      prev = sclk1;
      if (valid1) begin vcnt++; vt = c; d = data1; end
    end
    chk_cnt++; if (vcnt !== 1 || vt !== 34) $display("FAIL fast_valid got %0d at %0d want 1 at 34", vcnt, vt); else pass_cnt++;
    chk_cnt++; if (d !== 16'hA5C3) $display("FAIL fast_data got %h want a5c3", d); else pass_cnt++;
    chk_cnt++; if (nr !== 16 || gb !== 0 || lr !== 32) $display("FAIL fast_sclk got %0d rises, %0d misplaced, last %0d want 16, 0, 32", nr, gb, lr); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_patterns;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
    test_fast;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
